// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, 100 MHz default timing, sizing helpers and colour-order offsets
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4,
    S_LATCH = 3'd5
  } state_e;

  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_T0H      = 40;
  localparam int DEF_T0L      = 85;
  localparam int DEF_T1H      = 80;
  localparam int DEF_T1L      = 45;
  localparam int DEF_TRES     = 6000;

  localparam int R_OFS = 16;
  localparam int G_OFS = 8;
  localparam int B_OFS = 0;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction

  function automatic logic [23:0] to_grb(input logic [23:0] p);
    return {p[G_OFS+:8], p[R_OFS+:8], p[B_OFS+:8]};
  endfunction

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: loadable down-counter that pulses o_expire on its last count
module ws2812_bit_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_expire,
  output logic             o_idle
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // load wins over counting; the count parks at zero
  always_comb cnt_d = i_load ? i_val : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);

  // count register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;

  assign o_expire = cnt_q == CNT_W'(1);
  assign o_idle   = cnt_q == '0;

endmodule

// File: rtl/ws2812_strip_driver.sv
// ws2812_strip_driver: fetches NUM_LEDS RGB words, serialises them as GRB WS2812 NRZ, then latches; WS2812_BRIGHTNESS_EN adds global brightness scaling
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H      = DEF_T0H,
  parameter int T0L      = DEF_T0L,
  parameter int T1H      = DEF_T1H,
  parameter int T1L      = DEF_T1L,
  parameter int TRES     = DEF_TRES,
  localparam int ADDR_W  = max2(1, clog2(NUM_LEDS)),
  localparam int CNT_W   = clog2(max2(max2(max2(T0H, T0L), max2(T1H, T1L)), TRES) + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_bright,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [23:0]       i_pix_data,
  output logic              o_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam logic [CNT_W-1:0] TH0 = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] TL0 = CNT_W'(T0L);
  localparam logic [CNT_W-1:0] TH1 = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] TL1 = CNT_W'(T1L);
  localparam logic [CNT_W-1:0] TR  = CNT_W'(TRES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);

  state_e            state_q, state_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;
  logic              dout_q, dout_d;
  logic              ld, expire, idle;
  logic [CNT_W-1:0]  ld_val;
  logic [23:0]       pix_grb;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_q;

  // brightness is captured once per frame when the frame is accepted
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) bright_q <= '0;
    else if (state_q == S_IDLE && i_start) bright_q <= i_bright;

  assign pix_grb = to_grb({scale8(i_pix_data[23:16], bright_q),
                           scale8(i_pix_data[15:8], bright_q),
                           scale8(i_pix_data[7:0], bright_q)});
`else
  logic unused_bright;
  assign unused_bright = ^i_bright;
  assign pix_grb = to_grb(i_pix_data);
`endif

  ws2812_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ld),
    .i_val   (ld_val),
    .o_expire(expire),
    .o_idle  (idle)
  );

  // next-state logic; the last LOW of a pixel is two cycles short to absorb FETCH+LOAD
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    pix_d     = pix_q;
    frame_d   = frame_q;
    ld        = 1'b0;
    ld_val    = '0;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_FETCH;
        pix_d   = '0;
        frame_d = 1'b1;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d   = S_HIGH;
        shreg_d   = pix_grb;
        bit_idx_d = 5'd23;
        ld        = 1'b1;
        ld_val    = pix_grb[23] ? TH1 : TH0;
      end
      S_HIGH: if (expire) begin
        state_d = S_LOW;
        ld      = 1'b1;
        ld_val  = (shreg_q[23] ? TL1 : TL0) - (bit_idx_q == '0 ? CNT_W'(2) : '0);
      end
      S_LOW: if (expire) begin
        if (bit_idx_q != '0) begin
          state_d   = S_HIGH;
          shreg_d   = shreg_q << 1;
          bit_idx_d = bit_idx_q - 5'd1;
          ld        = 1'b1;
          ld_val    = shreg_q[22] ? TH1 : TH0;
        end else if (pix_q != LAST) begin
          state_d = S_FETCH;
          pix_d   = pix_q + ADDR_W'(1);
        end else begin
          state_d = S_LATCH;
          ld      = 1'b1;
          ld_val  = TR;
        end
      end
      S_LATCH: if (idle) begin
        ld     = 1'b1;
        ld_val = TR - CNT_W'(1);
      end else if (expire) begin
        state_d = S_IDLE;
        frame_d = 1'b0;
      end
      default: state_d = S_LATCH;
    endcase
  end

  assign done_d = state_q == S_LATCH && expire && frame_q;
  assign dout_d = state_d == S_HIGH;

  // state and datapath registers; reset lands in the post-reset latch with the line low
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q   <= S_LATCH;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      pix_q     <= '0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      pix_q     <= pix_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
    end

  assign o_rd_en = state_q == S_FETCH;
  assign o_addr  = pix_q;
  assign o_dout  = dout_q;
  assign o_busy  = state_q != S_IDLE;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// tb_ws2812_strip_driver: table-driven frames with a pulse-timing scoreboard plus handshake and reset sequences
module tb_ws2812_strip_driver;

  localparam int T0H = 2, T0L = 4, T1H = 4, T1L = 3, TRES = 10;

  typedef struct {
    logic [23:0] p0, p1;
    logic [7:0]  br;
    logic [23:0] e0, e1;
    logic [23:0] b0, b1;
  } vec_t;

  typedef struct {
    int hi;
    int ofs;
    bit first;
  } exp_t;

  logic        clk = 0, rst = 1, start = 0;
  logic [7:0]  bright = 0;
  logic        o_rd_en, o_dout, o_busy, o_done;
  logic [0:0]  o_addr;
  logic [2:0]  o_state;
  logic [23:0] pix_data = 0;
  logic [23:0] mem [2];

  int   checks = 0, failures = 0;
  int   edge_cnt = 0, start_edge = 0, last_fall = 0, rise_edge = 0, t0 = 0;
  bit   prev_dout = 0;
  exp_t cur = '{hi: -1, ofs: 0, first: 0};
  exp_t exp_q [$];
  int   addr_log [$];
  vec_t vecs [4];

  ws2812_strip_driver #(
    .NUM_LEDS(2), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .TRES(TRES)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_bright  (bright),
    .o_rd_en   (o_rd_en),
    .o_addr    (o_addr),
    .i_pix_data(pix_data),
    .o_dout    (o_dout),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) if (o_rd_en) pix_data <= mem[o_addr];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_rd_en) addr_log.push_back(int'(o_addr));
    if (o_dout && !prev_dout) begin
      rise_edge = edge_cnt;
      if (exp_q.size() == 0) begin
        chk("spare_rise", exp_q.size(), 1);
        cur.hi = -1;
      end else begin
        cur = exp_q.pop_front();
        if (cur.first) begin
          t0 = edge_cnt;
          chk("start_to_rise", edge_cnt - start_edge, 2);
        end
        chk("rise_ofs", edge_cnt - t0, cur.ofs);
      end
    end
    if (!o_dout && prev_dout) begin
      last_fall = edge_cnt;
      if (cur.hi > 0) chk("high_len", edge_cnt - rise_edge, cur.hi);
    end
    prev_dout = o_dout;
  end

  function automatic void push_frame(input logic [23:0] w0, input logic [23:0] w1,
                                     input int nbits, input bit trunc);
    logic [47:0] w;
    int ofs, k;
    w = {w0, w1};
    ofs = 0;
    k = 0;
    for (int i = 47; i >= 0 && k < nbits; i--) begin
      exp_t e;
      e.hi = w[i] ? T1H : T0H;
      e.ofs = ofs;
      e.first = i == 47;
      if (trunc && k == nbits - 1) e.hi = -1;
      exp_q.push_back(e);
      ofs += w[i] ? T1H + T1L : T0H + T0L;
      k++;
    end
  endfunction

  function automatic void pick(input vec_t v, output logic [23:0] a, output logic [23:0] b);
`ifdef WS2812_BRIGHTNESS_EN
    a = v.b0;
    b = v.b1;
`else
    a = v.e0;
    b = v.e1;
`endif
  endfunction

  task automatic wait_done(output int de, output bit ok);
    ok = 0;
    de = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1;
        de = edge_cnt;
        break;
      end
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic latch_after_release();
    int n = 0;
    bit bad = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_done || o_dout) bad = 1;
      if (o_state != 3'd5) break;
      if (!o_busy) bad = 1;
      n++;
    end
    chk("latch_len", n, TRES);
    chk("latch_quiet", bad, 0);
    chk("idle_after_latch", o_state, 0);
    chk("busy_idle", o_busy, 0);
  endtask

  task automatic run_frame(input vec_t v);
    logic [23:0] x0, x1;
    int de;
    bit ok;
    pick(v, x0, x1);
    mem[0] = v.p0;
    mem[1] = v.p1;
    addr_log.delete();
    push_frame(x0, x1, 48, 0);
    @(negedge clk);
    start = 1;
    bright = v.br;
    start_edge = edge_cnt + 1;
    @(negedge clk);
    start = 0;
    chk("busy_in_frame", o_busy, 1);
    wait_done(de, ok);
    if (ok) begin
      chk("busy_at_done", o_busy, 0);
      chk("state_at_done", o_state, 0);
      chk("fall_to_done", de - last_fall, (x1[0] ? T1L : T0L) - 2 + TRES);
      chk("queue_drained", exp_q.size(), 0);
      chk("reads", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
        chk("addr0", addr_log[0], 0);
        chk("addr1", addr_log[1], 1);
      end
      @(negedge clk);
      chk("done_width", o_done, 0);
    end
  endtask

  initial begin
    logic [23:0] x0, x1;
    int de;
    bit ok;
    vecs[0] = '{p0: 24'hFF0000, p1: 24'h000000, br: 8'd255,
                e0: 24'h00FF00, e1: 24'h000000, b0: 24'h00FF00, b1: 24'h000000};
    vecs[1] = '{p0: 24'h123456, p1: 24'hA5C3F0, br: 8'd255,
                e0: 24'h341256, e1: 24'hC3A5F0, b0: 24'h341256, b1: 24'hC3A5F0};
    vecs[2] = '{p0: 24'h804020, p1: 24'hFFFFFF, br: 8'd127,
                e0: 24'h408020, e1: 24'hFFFFFF, b0: 24'h204010, b1: 24'h7F7F7F};
    vecs[3] = '{p0: 24'h00FF80, p1: 24'h010203, br: 8'd0,
                e0: 24'hFF0080, e1: 24'h020103, b0: 24'h000000, b1: 24'h000000};

    repeat (3) @(negedge clk);
    chk("rst_state", o_state, 5);
    chk("rst_busy", o_busy, 1);
    chk("rst_dout", o_dout, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_addr", o_addr, 0);
    latch_after_release();

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    pick(vecs[0], x0, x1);
    mem[0] = vecs[0].p0;
    mem[1] = vecs[0].p1;
    addr_log.delete();
    push_frame(x0, x1, 48, 0);
    push_frame(x0, x1, 48, 0);
    @(negedge clk);
    start = 1;
    bright = 8'd255;
    start_edge = edge_cnt + 1;
    wait_done(de, ok);
    chk("held_start_reads", addr_log.size(), 2);
    start_edge = edge_cnt + 1;
    @(negedge clk);
    chk("restart_rd_en", o_rd_en, 1);
    chk("restart_state", o_state, 1);
    start = 0;
    wait_done(de, ok);
    chk("held_start_queue", exp_q.size(), 0);
    chk("held_start_reads2", addr_log.size(), 4);

    push_frame(x0, x1, 6, 1);
    @(negedge clk);
    start = 1;
    start_edge = edge_cnt + 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && edge_cnt != start_edge + 32; i++) @(negedge clk);
    chk("b5_high", o_dout, 1);
    #1 rst = 1;
    #1;
    chk("mid_rst_dout", o_dout, 0);
    chk("mid_rst_state", o_state, 5);
    chk("mid_rst_busy", o_busy, 1);
    latch_after_release();
    chk("mid_rst_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
